// File: rtl/scramble_addr_seq.sv
// scramble_addr_seq: frame sequencer placed in front of the scramble core.
// Each accepted word gets an index (0..FRAME_LEN-1). The index and the frame
// key are loaded into the scramble core, which is then given WAIT_CYCLES
// cycles to settle. The scrambled address it returns is used as the RAM write
// address for that word.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready is registered and is high only in ACCEPT. in_valid may be held
// high while in_ready is low; the word is neither taken nor dropped.
//
// Optional feature macro: SCR_COLLISION_CHECK_EN adds a written-address bitmap
// and a sticky err_collision flag. When it is undefined, err_collision is 0.
//
// state_dbg exposes the FSM state register for debug and checkers.
module scramble_addr_seq #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 8,
   parameter int FRAME_LEN   = 4096,
   parameter int WAIT_CYCLES = 13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [15:0]       key,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] scr_in_addr,
   output logic [15:0]       scr_key,
   output logic              scr_load_n,
   input  logic [ADDR_W-1:0] scr_out_addr,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err_collision,
   output logic [2:0]        state_dbg
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ACCEPT = 3'd1;
   localparam logic [2:0] S_LOAD   = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_WRITE  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(FRAME_LEN - 1);

   logic [2:0]        state;
   logic [ADDR_W-1:0] idx;
   logic [CNT_W-1:0]  wait_cnt;

   assign state_dbg = state;

   // Main sequencer: state transitions and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         idx         <= '0;
         wait_cnt    <= '0;
         in_ready    <= 1'b0;
         scr_load_n  <= 1'b1;
         scr_in_addr <= '0;
         scr_key     <= '0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  scr_key  <= key;
                  idx      <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  state    <= S_ACCEPT;
               end
            end
            S_ACCEPT: begin
               if (in_valid && in_ready) begin
                  mem_wdata   <= in_data;
                  scr_in_addr <= idx;
                  in_ready    <= 1'b0;
                  scr_load_n  <= 1'b0;
                  state       <= S_LOAD;
               end
            end
            S_LOAD: begin
               // Load pulse is exactly one cycle wide; the settle count starts next.
               scr_load_n <= 1'b1;
               wait_cnt   <= '0;
               state      <= S_WAIT;
            end
            S_WAIT: begin
               if (wait_cnt == CNT_LAST) begin
                  mem_addr <= scr_out_addr;
                  mem_we   <= 1'b1;
                  state    <= S_WRITE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_WRITE: begin
               mem_we <= 1'b0;
               // Terminal test on the current index, so idx never wraps,
               // even when FRAME_LEN equals 2**ADDR_W.
               if (idx == IDX_LAST) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  idx      <= idx + 1'b1;
                  in_ready <= 1'b1;
                  state    <= S_ACCEPT;
               end
            end
            S_DONE: begin
               // scr_key is held here until the next accepted start.
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               in_ready   <= 1'b0;
               scr_load_n <= 1'b1;
               mem_we     <= 1'b0;
               busy       <= 1'b0;
               done       <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

`ifdef SCR_COLLISION_CHECK_EN
   logic [(2**ADDR_W)-1:0] written_map;
   logic                   err_q;

   // Track written addresses; flag any second write to the same address in a frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         written_map <= '0;
         err_q       <= 1'b0;
      end else if (state == S_IDLE && start) begin
         written_map <= '0;
         err_q       <= 1'b0;
      end else if (state == S_WRITE) begin
         if (written_map[mem_addr]) begin
            err_q <= 1'b1;
         end
         written_map[mem_addr] <= 1'b1;
      end
   end

   assign err_collision = err_q;
`else
   assign err_collision = 1'b0;
`endif

endmodule

// File: tb/tb_scramble_addr_seq.sv
// Bench for scramble_addr_seq with a frame length of 4 words.
// The scramble core is replaced by a stub: scr_out_addr = ~scr_in_addr, or
// the constant 12'h005 when force_5 is set.
// A reference model of the frame is advanced on each rising edge. A single
// compare process checks all outputs against that model on every falling edge.
module tb_scramble_addr_seq;

   localparam int AW  = 12;
   localparam int DW  = 8;
   localparam int FL  = 4;
   localparam int WC  = 13;
   localparam int BIG = 32'h7fff_ffff;
   localparam int EW  = 32 + AW + DW;

   logic          clk;
   logic          reset;
   logic          start;
   logic [15:0]   key;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic [AW-1:0] scr_in_addr;
   logic [15:0]   scr_key;
   logic          scr_load_n;
   logic [AW-1:0] scr_out_addr;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          busy;
   logic          done;
   logic          err_collision;
   logic [2:0]    state_dbg;
   logic          force_5;

   scramble_addr_seq #(
      .ADDR_W(AW), .DATA_W(DW), .FRAME_LEN(FL), .WAIT_CYCLES(WC)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .key(key),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .scr_in_addr(scr_in_addr), .scr_key(scr_key), .scr_load_n(scr_load_n),
      .scr_out_addr(scr_out_addr), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .busy(busy), .done(done),
      .err_collision(err_collision), .state_dbg(state_dbg)
   );

   assign scr_out_addr = force_5 ? 12'h005 : ~scr_in_addr;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- counters and logs ----------------
   int vec    = 0;
   int miscmp = 0;
   int cyc    = 0;
   logic chk_en = 1'b0;
   int done_cnt = 0;

   int            log_c[$];
   logic [AW-1:0] log_a[$];
   logic [DW-1:0] log_d[$];
   int            hs_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [EW-1:0] exp_q[$];
   logic          m_active = 1'b0;
   int            m_words = 0;
   int            m_ready_from = BIG;
   int            m_done_cyc = -1;
   int            m_load_cyc = -1;
   int            m_load_idx = 0;
   logic [15:0]   m_key = '0;
   logic          m_err = 1'b0;
   logic          written [0:(1<<AW)-1];

   task automatic clear_written();
      for (int i = 0; i < (1 << AW); i++) written[i] = 1'b0;
   endtask

   // Frame rules per rising edge. For an edge numbered e:
   //   - an accepted word writes in cycle e+WC+2;
   //   - the next word can be accepted from cycle e+WC+3;
   //   - done is seen one cycle after the last write.
   always @(posedge clk) begin
      logic [AW-1:0] ia;
      logic [AW-1:0] wa;
      int e;
      e = cyc;
      if (reset) begin
         m_active = 1'b0; m_words = 0; m_ready_from = BIG; m_done_cyc = -1;
         m_load_cyc = -1; m_key = '0; m_err = 1'b0;
         exp_q.delete();
         clear_written();
      end else if (!m_active) begin
         if (start) begin
            m_active = 1'b1; m_key = key; m_words = 0; m_ready_from = e + 1;
            m_done_cyc = -1; m_err = 1'b0;
            clear_written();
         end
      end else if (e == m_done_cyc) begin
         m_active = 1'b0;
      end else if (in_valid && m_words < FL && e >= m_ready_from) begin
         ia = m_words[AW-1:0];
         wa = force_5 ? 12'h005 : ~ia;
         exp_q.push_back({32'(e + WC + 2), wa, in_data});
         hs_log.push_back(e);
         m_load_cyc = e + 1;
         m_load_idx = m_words;
         m_words++;
         if (m_words == FL) begin
            m_done_cyc   = e + WC + 3;
            m_ready_from = BIG;
         end else begin
            m_ready_from = e + WC + 3;
         end
      end
      cyc = cyc + 1;
   end

   // ---------------- scoreboard compare ----------------
   logic          e_ready;
   logic          e_we;
   logic [EW-1:0] f;
   always @(negedge clk) begin
      if (chk_en) begin
         e_ready = m_active && (m_words < FL) && (cyc >= m_ready_from);
         chk("in_ready", in_ready, e_ready);
         chk("scr_load_n", scr_load_n, (cyc == m_load_cyc) ? 1'b0 : 1'b1);
         if (cyc == m_load_cyc) chk("scr_in_addr", scr_in_addr, m_load_idx);
         chk("busy", busy, m_active);
         chk("done", done, m_active && (cyc == m_done_cyc));
         chk("scr_key", scr_key, m_key);
         chk("err_collision", err_collision, m_err);
         e_we = (exp_q.size() > 0) && (int'(exp_q[0][EW-1:AW+DW]) == cyc);
         chk("mem_we", mem_we, e_we);
         if (mem_we) begin
            log_c.push_back(cyc);
            log_a.push_back(mem_addr);
            log_d.push_back(mem_wdata);
         end
         if (e_we) begin
            f = exp_q.pop_front();
            if (mem_we) begin
               chk("mem_addr", mem_addr, f[AW+DW-1:DW]);
               chk("mem_wdata", mem_wdata, f[DW-1:0]);
            end
`ifdef SCR_COLLISION_CHECK_EN
            if (written[f[AW+DW-1:DW]]) m_err = 1'b1;
            written[f[AW+DW-1:DW]] = 1'b1;
`endif
         end
         if (done) done_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   // All tasks are entered and left on a falling edge.
   task automatic pulse_start(input logic [15:0] k);
      start = 1'b1; key = k;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_word(input logic [DW-1:0] d);
      int n;
      in_valid = 1'b1; in_data = d; n = 0;
      forever begin
         @(posedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            chk("send_timeout", 1, 0);
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (done_cnt < target && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("done_timeout", (done_cnt >= target) ? 1 : 0, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic clear_logs();
      log_c.delete(); log_a.delete(); log_d.delete(); hs_log.delete();
   endtask

   // Check the four writes from the B731 / A0..A3 frame against values worked out by hand.
   task automatic check_ref_frame(input string tag);
      logic [AW-1:0] ea [4];
      logic [DW-1:0] ed [4];
      ea = '{12'hFFF, 12'hFFE, 12'hFFD, 12'hFFC};
      ed = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      chk({tag, "_nwrites"}, log_a.size(), 4);
      if (log_a.size() == 4 && hs_log.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk({tag, "_addr"}, log_a[i], ea[i]);
            chk({tag, "_data"}, log_d[i], ed[i]);
            chk({tag, "_latency"}, log_c[i] - hs_log[i], 15);
         end
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int d0;
      reset = 1'b1; start = 1'b0; key = '0; in_valid = 1'b0; in_data = '0; force_5 = 1'b0;
      clear_written();

      // 1. reset held for two edges; all outputs must be at their reset values.
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_scr_load_n", scr_load_n, 1);
      chk("rst_scr_in_addr", scr_in_addr, 0);
      chk("rst_scr_key", scr_key, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_collision, 0);
      chk("rst_state", state_dbg, 0);
      chk_en = 1'b1;
      reset = 1'b0;
      @(negedge clk);

      // 2. reference frame, streamed back to back.
      clear_logs();
      d0 = done_cnt;
      pulse_start(16'hB731);
      for (int i = 0; i < 4; i++) send_word(8'hA0 + 8'(i));
      in_valid = 1'b0;
      wait_done(d0 + 1);
      check_ref_frame("t2");
      chk("t2_done_count", done_cnt - d0, 1);
      chk("t2_scr_key", scr_key, 16'hB731);
      if (log_c.size() == 4) chk("t2_throughput", log_c[1] - log_c[0], 16);

      // 3. 20-cycle in_valid gap after word 1.
      clear_logs();
      d0 = done_cnt;
      pulse_start(16'h1111);
      send_word(8'h10);
      send_word(8'h11);
      in_valid = 1'b0;
      repeat (20) @(negedge clk);
      chk("t3_ready_in_gap", in_ready, 1);
      send_word(8'h12);
      send_word(8'h13);
      in_valid = 1'b0;
      wait_done(d0 + 1);
      chk("t3_nwrites", log_a.size(), 4);
      if (log_a.size() == 4) begin
         chk("t3_last_addr", log_a[3], 12'hFFC);
         chk("t3_last_data", log_d[3], 8'h13);
      end

      // 4. reset during WAIT of word 2, then a fresh frame.
      clear_logs();
      pulse_start(16'h2222);
      send_word(8'h20);
      send_word(8'h21);
      send_word(8'h22);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t4_busy_after_rst", busy, 0);
      chk("t4_state_after_rst", state_dbg, 0);
      repeat (20) @(negedge clk);
      chk("t4_nwrites_aborted", log_a.size(), 2);
      clear_logs();
      d0 = done_cnt;
      pulse_start(16'h3333);
      for (int i = 0; i < 4; i++) send_word(8'h30 + 8'(i));
      in_valid = 1'b0;
      wait_done(d0 + 1);
      chk("t4_nwrites", log_a.size(), 4);
      if (log_a.size() == 4) chk("t4_first_addr", log_a[0], 12'hFFF);

      // 5. start pulses while busy are ignored.
      clear_logs();
      d0 = done_cnt;
      pulse_start(16'hB731);
      send_word(8'hA0);
      repeat (3) @(negedge clk);
      pulse_start(16'h1234);
      send_word(8'hA1);
      pulse_start(16'h5678);
      send_word(8'hA2);
      send_word(8'hA3);
      in_valid = 1'b0;
      wait_done(d0 + 1);
      check_ref_frame("t5");
      chk("t5_scr_key", scr_key, 16'hB731);

      // 6. collision flag.
`ifdef SCR_COLLISION_CHECK_EN
      force_5 = 1'b1;
      clear_logs();
      d0 = done_cnt;
      pulse_start(16'h4444);
      for (int i = 0; i < 4; i++) send_word(8'h40 + 8'(i));
      in_valid = 1'b0;
      wait_done(d0 + 1);
      chk("t6_err_sticky", err_collision, 1);
      force_5 = 1'b0;
`else
      chk("t6_err_tied", err_collision, 0);
`endif

      chk("final_idle_busy", busy, 0);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end

   // Global time bound.
   initial begin
      #500000;
      $display("FAIL global_timeout: got timeout, expected finish");
      $fatal(1, "timeout");
   end

endmodule
